uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 34 +++
 rtl/uart_rx.sv | 128 ++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line and received-byte signal bundle for uart_rx
//
// Signals:
//   rx        serial line in, idle high
//   po_data   last correctly framed byte
//   po_flag   one-cycle pulse, po_data just updated
//   rx_busy   frame in progress
//   frame_err one-cycle pulse, stop bit sampled low
// Modports:
//   slave  - receiver side (uart_rx)
//   master - line driver / byte consumer side
interface uart_rx_if;
    logic       rx;
    logic [7:0] po_data;
    logic       po_flag;
    logic       rx_busy;
    logic       frame_err;

    modport slave (
        input  rx,
        output po_data,
        output po_flag,
        output rx_busy,
        output frame_err
    );

    modport master (
        output rx,
        input  po_data,
        input  po_flag,
        input  rx_busy,
        input  frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and framing-error pulse
//
// Parameters:
//   UART_BPS  serial baud rate
//   CLK_FREQ  sys_clk frequency in Hz
// Ports:
//   sys_clk   system clock
//   sys_rst   asynchronous active-high reset
//   bus       uart_rx_if.slave: rx in; po_data, po_flag, rx_busy, frame_err out
module uart_rx #(
    parameter int UART_BPS = 9600,
    parameter int CLK_FREQ = 50000000
) (
    input  logic     sys_clk,
    input  logic     sys_rst,
    uart_rx_if.slave bus
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
    localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam logic [15:0] BAUD_LAST = 16'(BAUD_CNT_MAX - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF_CNT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state, state_next;
    logic        rx_s1, rx_s, rx_prev;
    logic [15:0] baud_cnt, baud_cnt_next;
    logic [2:0]  bit_cnt, bit_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  po_data_q, po_data_next;
    logic        po_flag_q, po_flag_next;
    logic        frame_err_q, frame_err_next;

    // Synchronizer plus one history flop for edge detection. Resetting all to
    // 1 means a line that stays low after a break or bad stop bit never
    // produces a falling edge until it has gone high again.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_s1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.rx;
            rx_s    <= rx_s1;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state       <= IDLE;
            baud_cnt    <= 16'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            po_data_q   <= 8'h00;
            po_flag_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state       <= state_next;
            baud_cnt    <= baud_cnt_next;
            bit_cnt     <= bit_cnt_next;
            shift_reg   <= shift_next;
            po_data_q   <= po_data_next;
            po_flag_q   <= po_flag_next;
            frame_err_q <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state;
        baud_cnt_next  = baud_cnt + 16'd1;
        bit_cnt_next   = bit_cnt;
        shift_next     = shift_reg;
        po_data_next   = po_data_q;
        po_flag_next   = 1'b0;
        frame_err_next = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_next = 16'd0;
                if (rx_prev && !rx_s) begin
                    state_next = START;
                end
            end
            START: begin
                // Re-check the start bit at its centre to reject glitches.
                if (baud_cnt == HALF_LAST) begin
                    baud_cnt_next = 16'd0;
                    state_next    = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_next       = 16'd0;
                    shift_next[bit_cnt] = rx_s;
                    if (bit_cnt == 3'd7) begin
                        bit_cnt_next = 3'd0;
                        state_next   = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a back-to-back start edge is caught.
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_next = 16'd0;
                    state_next    = IDLE;
                    if (rx_s) begin
                        po_data_next = shift_reg;
                        po_flag_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                baud_cnt_next = 16'd0;
            end
        endcase
    end

    assign bus.po_data   = po_data_q;
    assign bus.po_flag   = po_flag_q;
    assign bus.frame_err = frame_err_q;
    assign bus.rx_busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx with frame-level model
module tb_uart_rx;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   cyc = 0;

    uart_rx_if bus();

    uart_rx #(.UART_BPS(1), .CLK_FREQ(16)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         stop_cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] model_last = 8'h00;
    logic       busy_prev  = 1'b0;
    int         flag_cnt   = 0;
    int         err_cnt    = 0;
    int         checks     = 0;
    int         failures   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    // Frame-level model: each frame whose stop bit is driven must produce
    // exactly one event (byte or framing error) during the stop bit.
    always @(negedge sys_clk) begin
        ev_t ev;
        if (sys_rst) begin
            model_last = 8'h00;
            busy_prev  = 1'b0;
        end else begin
            if (bus.po_flag || bus.frame_err) begin
                check("flag_err_exclusive", {31'd0, bus.po_flag & bus.frame_err}, 32'd0);
                if (bus.po_flag) flag_cnt++;
                if (bus.frame_err) err_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_event", {30'd0, bus.po_flag, bus.frame_err}, 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("event_kind", {31'd0, bus.frame_err}, {31'd0, ev.err});
                    if (!ev.err) model_last = ev.data;
                    check("event_in_stop_bit",
                          {31'd0, (cyc >= ev.stop_cyc + 6) && (cyc <= ev.stop_cyc + 15)}, 32'd1);
                    check("busy_drops_at_event", {30'd0, bus.rx_busy, busy_prev}, 32'd1);
                end
            end
            if (exp_q.size() > 0 && cyc > exp_q[0].stop_cyc + 20) begin
                check("missing_event", exp_q.size(), 32'd0);
                void'(exp_q.pop_front());
            end
            check("po_data", {24'd0, bus.po_data}, {24'd0, model_last});
            busy_prev = bus.rx_busy;
        end
    end

    task automatic drive_bit(input logic v);
        @(negedge sys_clk);
        bus.rx = v;
        repeat (15) @(negedge sys_clk);
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t ev;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        @(negedge sys_clk);
        bus.rx      = stop_ok;
        ev.err      = !stop_ok;
        ev.data     = b;
        ev.stop_cyc = cyc;
        exp_q.push_back(ev);
        repeat (15) @(negedge sys_clk);
        if (!stop_ok) begin
            drive_bit(1'b1);
            drive_bit(1'b1);
        end
    endtask

    task automatic glitch(input int low_cycles, output int busy_cycles);
        busy_cycles = 0;
        @(negedge sys_clk);
        bus.rx = 1'b0;
        for (int i = 0; i < 34; i++) begin
            @(negedge sys_clk);
            if (bus.rx_busy) busy_cycles++;
            if (i == low_cycles - 1) bus.rx = 1'b1;
        end
    endtask

    initial begin
        int f0, e0, bc, r, gap;
        logic [7:0] b;
        bit ok;

        bus.rx = 1'b1;
        repeat (3) @(negedge sys_clk);
        #1;
        check("rst_po_data", {24'd0, bus.po_data}, 32'h00);
        check("rst_flags", {29'd0, bus.po_flag, bus.frame_err, bus.rx_busy}, 32'd0);
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        idle(20);
        check("post_rst_idle", {30'd0, bus.rx_busy, bus.po_flag}, 32'd0);

        f0 = flag_cnt;
        send_frame(8'hA5, 1'b1);
        idle(20);
        check("a5_data", {24'd0, bus.po_data}, 32'hA5);
        check("a5_one_flag", flag_cnt - f0, 32'd1);

        f0 = flag_cnt; e0 = err_cnt;
        glitch(3, bc);
        check("glitch_busy_le8", {31'd0, bc >= 1 && bc <= 8}, 32'd1);
        check("glitch_no_event", (flag_cnt - f0) + (err_cnt - e0), 32'd0);

        f0 = flag_cnt; e0 = err_cnt;
        send_frame(8'h3C, 1'b0);
        idle(20);
        check("3c_one_err", err_cnt - e0, 32'd1);
        check("3c_no_flag", flag_cnt - f0, 32'd0);
        check("3c_data_kept", {24'd0, bus.po_data}, 32'hA5);

        f0 = flag_cnt;
        send_frame(8'h00, 1'b1);
        check("b2b_first", {24'd0, bus.po_data}, 32'h00);
        send_frame(8'hFF, 1'b1);
        idle(20);
        check("b2b_two_flags", flag_cnt - f0, 32'd2);
        check("b2b_second", {24'd0, bus.po_data}, 32'hFF);

        send_frame(8'h01, 1'b1);
        idle(20);
        check("lsb_first", {24'd0, bus.po_data}, 32'h01);

        b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        @(negedge sys_clk);
        bus.rx = b[4];
        repeat (8) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        check("midframe_rst_busy", {31'd0, bus.rx_busy}, 32'd0);
        check("midframe_rst_data", {24'd0, bus.po_data}, 32'h00);
        repeat (3) @(negedge sys_clk);
        bus.rx = 1'b1;
        @(negedge sys_clk);
        #2 sys_rst = 1'b0;
        f0 = flag_cnt; e0 = err_cnt;
        idle(40);
        check("after_rst_data", {24'd0, bus.po_data}, 32'h00);
        check("after_rst_quiet", (flag_cnt - f0) + (err_cnt - e0), 32'd0);
        send_frame(8'h81, 1'b1);
        idle(20);
        check("only_81", flag_cnt - f0, 32'd1);
        check("data_81", {24'd0, bus.po_data}, 32'h81);

        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                f0 = flag_cnt; e0 = err_cnt;
                glitch($urandom_range(1, 5), bc);
                check("rnd_glitch_busy", {31'd0, bc <= 8}, 32'd1);
                check("rnd_glitch_quiet", (flag_cnt - f0) + (err_cnt - e0), 32'd0);
            end else begin
                b   = 8'($urandom);
                ok  = ($urandom_range(0, 4) != 0);
                send_frame(b, ok);
                gap = $urandom_range(0, 20);
                idle(gap);
            end
        end

        idle(60);
        check("all_events_seen", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
